rob_core: RTL and testbench

ROB_CORE -- requirements
Module: rob_core

---
 rtl/rob_core.sv | 167 ++++++++++++++++
 tb/tb_rob_core.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_core.sv
// Reorder buffer: in-order dispatch into a circular buffer, out-of-order completion
// marking, in-order multi-lane retirement and full flush on a retiring mispredicted branch.
module rob_core #(
   parameter int unsigned C_DP_NUM         = 2,
   parameter int unsigned C_RT_NUM         = 2,
   parameter int unsigned C_CDB_NUM        = 2,
   parameter int unsigned C_ROB_ENTRY_NUM  = 32,
   parameter int unsigned C_TAG_IDX_WIDTH  = 6,
   parameter int unsigned C_ARCH_IDX_WIDTH = 5
) (
   input  logic                                                clk_i,
   input  logic                                                rst_i,
   input  logic [C_DP_NUM-1:0]                                 dp_valid_i,
   input  logic [C_DP_NUM*C_ARCH_IDX_WIDTH-1:0]                dp_arch_reg_i,
   input  logic [C_DP_NUM*C_TAG_IDX_WIDTH-1:0]                 dp_phy_reg_i,
   input  logic [C_DP_NUM*C_TAG_IDX_WIDTH-1:0]                 dp_old_phy_reg_i,
   output logic [$clog2(C_DP_NUM+1)-1:0]                       dp_num_avail_o,
   output logic [C_DP_NUM*$clog2(C_ROB_ENTRY_NUM)-1:0]         dp_rob_idx_o,
   input  logic [C_CDB_NUM-1:0]                                cdb_valid_i,
   input  logic [C_CDB_NUM*$clog2(C_ROB_ENTRY_NUM)-1:0]        cdb_rob_idx_i,
   input  logic [C_CDB_NUM-1:0]                                cdb_br_mispredict_i,
   output logic [C_RT_NUM-1:0]                                 rt_wr_en_o,
   output logic [C_RT_NUM*C_ARCH_IDX_WIDTH-1:0]                rt_arch_reg_o,
   output logic [C_RT_NUM*C_TAG_IDX_WIDTH-1:0]                 rt_phy_reg_o,
   output logic [C_RT_NUM*C_TAG_IDX_WIDTH-1:0]                 rt_old_phy_reg_o,
   output logic [C_RT_NUM-1:0]                                 rt_retire_o,
   output logic                                                rollback_o,
   output logic                                                empty_o
);

   localparam int unsigned IDX_W  = $clog2(C_ROB_ENTRY_NUM);
   localparam int unsigned CNT_W  = IDX_W + 1;
   localparam int unsigned AV_W   = $clog2(C_DP_NUM + 1);
   localparam int unsigned ARCH_W = C_ARCH_IDX_WIDTH;
   localparam int unsigned TAG_W  = C_TAG_IDX_WIDTH;

   logic [IDX_W-1:0]           head_q, tail_q, head_d, tail_d;
   logic [CNT_W-1:0]           count_q, count_d;
   logic [C_ROB_ENTRY_NUM-1:0] valid_q, done_q, mp_q;
   logic [C_ROB_ENTRY_NUM-1:0] valid_d, done_d, mp_d;
   logic [ARCH_W-1:0]          arch_q [C_ROB_ENTRY_NUM];
   logic [TAG_W-1:0]           phy_q  [C_ROB_ENTRY_NUM];
   logic [TAG_W-1:0]           old_q  [C_ROB_ENTRY_NUM];

   logic [CNT_W-1:0]    free_c;
   logic [C_DP_NUM-1:0] dp_accept;
   logic [CNT_W-1:0]    dp_cnt, rt_cnt;
   logic                rt_ok;

   assign empty_o = (count_q == '0);

   // Free space comes from the registered count only.
   always_comb begin
      free_c = CNT_W'(C_ROB_ENTRY_NUM) - count_q;
      if (free_c >= CNT_W'(C_DP_NUM)) dp_num_avail_o = AV_W'(C_DP_NUM);
      else                            dp_num_avail_o = AV_W'(free_c);
   end

   always_comb begin
      dp_rob_idx_o = '0;
      dp_accept    = '0;
      dp_cnt       = '0;
      for (int k = 0; k < int'(C_DP_NUM); k++) begin
         dp_rob_idx_o[k*IDX_W +: IDX_W] = tail_q + IDX_W'(k);
         if (dp_valid_i[k] && (k < int'(dp_num_avail_o))) begin
            dp_accept[k] = 1'b1;
            dp_cnt       = dp_cnt + CNT_W'(1);
         end
      end
   end

   // A lane retires only behind a contiguous run of done, non-mispredicted entries.
   always_comb begin
      rt_retire_o      = '0;
      rt_wr_en_o       = '0;
      rt_arch_reg_o    = '0;
      rt_phy_reg_o     = '0;
      rt_old_phy_reg_o = '0;
      rollback_o       = 1'b0;
      rt_cnt           = '0;
      rt_ok            = 1'b1;
      for (int j = 0; j < int'(C_RT_NUM); j++) begin
         rt_arch_reg_o[j*ARCH_W +: ARCH_W]   = arch_q[head_q + IDX_W'(j)];
         rt_phy_reg_o[j*TAG_W +: TAG_W]      = phy_q[head_q + IDX_W'(j)];
         rt_old_phy_reg_o[j*TAG_W +: TAG_W]  = old_q[head_q + IDX_W'(j)];
         if (rt_ok && valid_q[head_q + IDX_W'(j)] && done_q[head_q + IDX_W'(j)]) begin
            rt_retire_o[j] = 1'b1;
            rt_wr_en_o[j]  = |arch_q[head_q + IDX_W'(j)];
            rt_cnt         = rt_cnt + CNT_W'(1);
            if (mp_q[head_q + IDX_W'(j)]) begin
               rollback_o = 1'b1;
               rt_ok      = 1'b0;
            end
         end else begin
            rt_ok = 1'b0;
         end
      end
   end

   always_comb begin
      valid_d = valid_q;
      done_d  = done_q;
      mp_d    = mp_q;
      head_d  = head_q + IDX_W'(rt_cnt);
      tail_d  = tail_q + IDX_W'(dp_cnt);
      count_d = count_q + dp_cnt - rt_cnt;
      for (int c = 0; c < int'(C_CDB_NUM); c++) begin
         if (cdb_valid_i[c] && valid_q[cdb_rob_idx_i[c*IDX_W +: IDX_W]]) begin
            done_d[cdb_rob_idx_i[c*IDX_W +: IDX_W]] = 1'b1;
            mp_d[cdb_rob_idx_i[c*IDX_W +: IDX_W]]   = mp_d[cdb_rob_idx_i[c*IDX_W +: IDX_W]]
                                                      | cdb_br_mispredict_i[c];
         end
      end
      for (int j = 0; j < int'(C_RT_NUM); j++) begin
         if (rt_retire_o[j]) valid_d[head_q + IDX_W'(j)] = 1'b0;
      end
      for (int k = 0; k < int'(C_DP_NUM); k++) begin
         if (dp_accept[k]) begin
            valid_d[tail_q + IDX_W'(k)] = 1'b1;
            done_d[tail_q + IDX_W'(k)]  = 1'b0;
            mp_d[tail_q + IDX_W'(k)]    = 1'b0;
         end
      end
      // Rollback flushes everything, including this cycle's dispatch and completions.
      if (rollback_o) begin
         valid_d = '0;
         done_d  = '0;
         mp_d    = '0;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
         done_q  <= '0;
         mp_q    <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         mp_q    <= mp_d;
      end
   end

   // Payload needs no reset; it is only observed behind a valid bit.
   always_ff @(posedge clk_i) begin
      for (int k = 0; k < int'(C_DP_NUM); k++) begin
         if (dp_accept[k] && !rollback_o) begin
            arch_q[tail_q + IDX_W'(k)] <= dp_arch_reg_i[k*ARCH_W +: ARCH_W];
            phy_q[tail_q + IDX_W'(k)]  <= dp_phy_reg_i[k*TAG_W +: TAG_W];
            old_q[tail_q + IDX_W'(k)]  <= dp_old_phy_reg_i[k*TAG_W +: TAG_W];
         end
      end
   end

   a_dp_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
      $countones(dp_valid_i) <= int'(dp_num_avail_o));

endmodule

// File: tb/tb_rob_core.sv
// Directed testbench for rob_core with per-scenario tasks and inline checks.
module tb_rob_core;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic [1:0]  dp_valid_i = '0;
   logic [9:0]  dp_arch_reg_i = '0;
   logic [11:0] dp_phy_reg_i = '0;
   logic [11:0] dp_old_phy_reg_i = '0;
   logic [1:0]  dp_num_avail_o;
   logic [9:0]  dp_rob_idx_o;
   logic [1:0]  cdb_valid_i = '0;
   logic [9:0]  cdb_rob_idx_i = '0;
   logic [1:0]  cdb_br_mispredict_i = '0;
   logic [1:0]  rt_wr_en_o;
   logic [9:0]  rt_arch_reg_o;
   logic [11:0] rt_phy_reg_o;
   logic [11:0] rt_old_phy_reg_o;
   logic [1:0]  rt_retire_o;
   logic        rollback_o;
   logic        empty_o;

   int n_cmp = 0;
   int n_err = 0;

   rob_core dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .dp_valid_i(dp_valid_i), .dp_arch_reg_i(dp_arch_reg_i),
      .dp_phy_reg_i(dp_phy_reg_i), .dp_old_phy_reg_i(dp_old_phy_reg_i),
      .dp_num_avail_o(dp_num_avail_o), .dp_rob_idx_o(dp_rob_idx_o),
      .cdb_valid_i(cdb_valid_i), .cdb_rob_idx_i(cdb_rob_idx_i),
      .cdb_br_mispredict_i(cdb_br_mispredict_i),
      .rt_wr_en_o(rt_wr_en_o), .rt_arch_reg_o(rt_arch_reg_o),
      .rt_phy_reg_o(rt_phy_reg_o), .rt_old_phy_reg_o(rt_old_phy_reg_o),
      .rt_retire_o(rt_retire_o), .rollback_o(rollback_o), .empty_o(empty_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_dp(input logic [1:0] v,
                         input logic [4:0] a0, input logic [5:0] p0, input logic [5:0] o0,
                         input logic [4:0] a1, input logic [5:0] p1, input logic [5:0] o1);
      dp_valid_i       = v;
      dp_arch_reg_i    = {a1, a0};
      dp_phy_reg_i     = {p1, p0};
      dp_old_phy_reg_i = {o1, o0};
   endtask

   task automatic set_cdb(input logic [1:0] v, input logic [4:0] i0, input logic m0,
                          input logic [4:0] i1, input logic m1);
      cdb_valid_i         = v;
      cdb_rob_idx_i       = {i1, i0};
      cdb_br_mispredict_i = {m1, m0};
   endtask

   task automatic idle();
      set_dp(2'b00, 5'd0, 6'd0, 6'd0, 5'd0, 6'd0, 6'd0);
      set_cdb(2'b00, 5'd0, 1'b0, 5'd0, 1'b0);
   endtask

   task automatic do_reset();
      idle();
      @(negedge clk_i);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      rst_i = 1'b1;
      #1;
      n_cmp++; if (empty_o !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", empty_o); end
      n_cmp++; if (dp_num_avail_o !== 2'd2) begin n_err++; $display("FAIL reset_avail got %0d want 2", dp_num_avail_o); end
      n_cmp++; if (rt_retire_o !== 2'b00) begin n_err++; $display("FAIL reset_retire got %b want 00", rt_retire_o); end
      n_cmp++; if (rt_wr_en_o !== 2'b00) begin n_err++; $display("FAIL reset_wr_en got %b want 00", rt_wr_en_o); end
      n_cmp++; if (rollback_o !== 1'b0) begin n_err++; $display("FAIL reset_rollback got %b want 0", rollback_o); end
      tick();
      rst_i = 1'b0;
   endtask

   task automatic test_basic();
      set_dp(2'b11, 5'd3, 6'd33, 6'd3, 5'd0, 6'd34, 6'd0);
      #1;
      n_cmp++; if (dp_rob_idx_o !== {5'd1, 5'd0}) begin n_err++; $display("FAIL basic_rob_idx got %h want 020", dp_rob_idx_o); end
      tick();
      idle();
      n_cmp++; if (empty_o !== 1'b0) begin n_err++; $display("FAIL basic_not_empty got %b want 0", empty_o); end
      n_cmp++; if (rt_retire_o !== 2'b00) begin n_err++; $display("FAIL basic_no_retire got %b want 00", rt_retire_o); end
      set_cdb(2'b11, 5'd0, 1'b0, 5'd1, 1'b0);
      tick();
      idle();
      n_cmp++; if (rt_retire_o !== 2'b11) begin n_err++; $display("FAIL basic_retire got %b want 11", rt_retire_o); end
      n_cmp++; if (rt_wr_en_o !== 2'b01) begin n_err++; $display("FAIL basic_wr_en got %b want 01", rt_wr_en_o); end
      n_cmp++; if (rt_phy_reg_o[5:0] !== 6'd33) begin n_err++; $display("FAIL basic_phy got %0d want 33", rt_phy_reg_o[5:0]); end
      n_cmp++; if (rt_old_phy_reg_o[5:0] !== 6'd3) begin n_err++; $display("FAIL basic_old got %0d want 3", rt_old_phy_reg_o[5:0]); end
      n_cmp++; if (rt_arch_reg_o[4:0] !== 5'd3) begin n_err++; $display("FAIL basic_arch got %0d want 3", rt_arch_reg_o[4:0]); end
      n_cmp++; if (rollback_o !== 1'b0) begin n_err++; $display("FAIL basic_rollback got %b want 0", rollback_o); end
      tick();
      n_cmp++; if (empty_o !== 1'b1) begin n_err++; $display("FAIL basic_empty_after got %b want 1", empty_o); end
      n_cmp++; if (dp_rob_idx_o[4:0] !== 5'd2) begin n_err++; $display("FAIL basic_tail got %0d want 2", dp_rob_idx_o[4:0]); end
   endtask

   // Starts with head=tail=2 and an empty buffer.
   task automatic test_full();
      for (int i = 0; i < 16; i++) begin
         set_dp(2'b11, 5'd1, 6'(2*i), 6'd1, 5'd2, 6'(2*i+1), 6'd2);
         tick();
         if (i == 14) begin
            n_cmp++; if (dp_num_avail_o !== 2'd2) begin n_err++; $display("FAIL full_avail30 got %0d want 2", dp_num_avail_o); end
         end
      end
      idle();
      n_cmp++; if (dp_num_avail_o !== 2'd0) begin n_err++; $display("FAIL full_avail0 got %0d want 0", dp_num_avail_o); end
      n_cmp++; if (dp_rob_idx_o !== {5'd3, 5'd2}) begin n_err++; $display("FAIL full_rob_idx got %h want 062", dp_rob_idx_o); end
      set_cdb(2'b11, 5'd2, 1'b0, 5'd3, 1'b0);
      tick();
      idle();
      n_cmp++; if (rt_retire_o !== 2'b11) begin n_err++; $display("FAIL full_retire got %b want 11", rt_retire_o); end
      n_cmp++; if (dp_num_avail_o !== 2'd0) begin n_err++; $display("FAIL full_avail_same_cycle got %0d want 0", dp_num_avail_o); end
      tick();
      n_cmp++; if (dp_num_avail_o !== 2'd2) begin n_err++; $display("FAIL full_avail_after got %0d want 2", dp_num_avail_o); end
      n_cmp++; if (rt_retire_o !== 2'b00) begin n_err++; $display("FAIL full_retire_after got %b want 00", rt_retire_o); end
   endtask

   task automatic test_ooo();
      set_dp(2'b11, 5'd5, 6'd40, 6'd5, 5'd6, 6'd41, 6'd6);
      tick();
      idle();
      set_cdb(2'b01, 5'd1, 1'b0, 5'd0, 1'b0);
      tick();
      idle();
      n_cmp++; if (rt_retire_o !== 2'b00) begin n_err++; $display("FAIL ooo_hold got %b want 00", rt_retire_o); end
      tick();
      n_cmp++; if (rt_retire_o !== 2'b00) begin n_err++; $display("FAIL ooo_hold2 got %b want 00", rt_retire_o); end
      n_cmp++; if (empty_o !== 1'b0) begin n_err++; $display("FAIL ooo_not_empty got %b want 0", empty_o); end
      set_cdb(2'b01, 5'd0, 1'b0, 5'd0, 1'b0);
      tick();
      idle();
      n_cmp++; if (rt_retire_o !== 2'b11) begin n_err++; $display("FAIL ooo_retire got %b want 11", rt_retire_o); end
      n_cmp++; if (rt_wr_en_o !== 2'b11) begin n_err++; $display("FAIL ooo_wr_en got %b want 11", rt_wr_en_o); end
      n_cmp++; if (rt_phy_reg_o[11:6] !== 6'd41) begin n_err++; $display("FAIL ooo_phy1 got %0d want 41", rt_phy_reg_o[11:6]); end
      tick();
      n_cmp++; if (empty_o !== 1'b1) begin n_err++; $display("FAIL ooo_empty got %b want 1", empty_o); end
   endtask

   task automatic test_mispredict();
      set_dp(2'b11, 5'd7, 6'd50, 6'd7, 5'd8, 6'd51, 6'd8);
      tick();
      idle();
      set_cdb(2'b11, 5'd0, 1'b1, 5'd1, 1'b0);
      tick();
      set_cdb(2'b00, 5'd0, 1'b0, 5'd0, 1'b0);
      n_cmp++; if (rollback_o !== 1'b1) begin n_err++; $display("FAIL mp_rollback got %b want 1", rollback_o); end
      n_cmp++; if (rt_retire_o !== 2'b01) begin n_err++; $display("FAIL mp_retire got %b want 01", rt_retire_o); end
      n_cmp++; if (rt_wr_en_o !== 2'b01) begin n_err++; $display("FAIL mp_wr_en got %b want 01", rt_wr_en_o); end
      n_cmp++; if (rt_phy_reg_o[5:0] !== 6'd50) begin n_err++; $display("FAIL mp_phy got %0d want 50", rt_phy_reg_o[5:0]); end
      set_dp(2'b11, 5'd9, 6'd52, 6'd9, 5'd10, 6'd53, 6'd10);
      tick();
      idle();
      n_cmp++; if (empty_o !== 1'b1) begin n_err++; $display("FAIL mp_empty got %b want 1", empty_o); end
      n_cmp++; if (rollback_o !== 1'b0) begin n_err++; $display("FAIL mp_rollback_after got %b want 0", rollback_o); end
      n_cmp++; if (dp_rob_idx_o !== {5'd1, 5'd0}) begin n_err++; $display("FAIL mp_tail got %h want 020", dp_rob_idx_o); end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 15; i++) begin
         set_dp(2'b11, 5'd0, 6'd1, 6'd1, 5'd0, 6'd2, 6'd2);
         tick();
      end
      set_dp(2'b01, 5'd0, 6'd1, 6'd1, 5'd0, 6'd0, 6'd0);
      tick();
      idle();
      for (int i = 0; i < 16; i++) begin
         set_cdb((i == 15) ? 2'b01 : 2'b11, 5'(2*i), 1'b0, 5'(2*i+1), 1'b0);
         tick();
      end
      idle();
      repeat (3) tick();
      n_cmp++; if (empty_o !== 1'b1) begin n_err++; $display("FAIL wrap_drained got %b want 1", empty_o); end
      n_cmp++; if (dp_rob_idx_o !== {5'd0, 5'd31}) begin n_err++; $display("FAIL wrap_rob_idx got %h want 01f", dp_rob_idx_o); end
      set_dp(2'b11, 5'd11, 6'd20, 6'd11, 5'd12, 6'd21, 6'd12);
      tick();
      idle();
      set_cdb(2'b11, 5'd0, 1'b0, 5'd31, 1'b0);
      tick();
      idle();
      n_cmp++; if (rt_retire_o !== 2'b11) begin n_err++; $display("FAIL wrap_retire got %b want 11", rt_retire_o); end
      n_cmp++; if (rt_arch_reg_o !== {5'd12, 5'd11}) begin n_err++; $display("FAIL wrap_arch got %h want 18b", rt_arch_reg_o); end
      n_cmp++; if (rt_phy_reg_o[5:0] !== 6'd20) begin n_err++; $display("FAIL wrap_phy got %0d want 20", rt_phy_reg_o[5:0]); end
      tick();
      n_cmp++; if (empty_o !== 1'b1) begin n_err++; $display("FAIL wrap_empty got %b want 1", empty_o); end
      n_cmp++; if (dp_rob_idx_o[4:0] !== 5'd1) begin n_err++; $display("FAIL wrap_tail got %0d want 1", dp_rob_idx_o[4:0]); end
   endtask

   task automatic test_async_reset();
      set_dp(2'b11, 5'd4, 6'd60, 6'd4, 5'd5, 6'd61, 6'd5);
      tick();
      idle();
      set_cdb(2'b11, 5'd0, 1'b0, 5'd1, 1'b0);
      tick();
      idle();
      n_cmp++; if (rt_retire_o !== 2'b11) begin n_err++; $display("FAIL arst_pre_retire got %b want 11", rt_retire_o); end
      set_dp(2'b11, 5'd6, 6'd62, 6'd6, 5'd7, 6'd63, 6'd7);
      #2;
      rst_i = 1'b1;
      #1;
      n_cmp++; if (rt_retire_o !== 2'b00) begin n_err++; $display("FAIL arst_retire got %b want 00", rt_retire_o); end
      n_cmp++; if (rt_wr_en_o !== 2'b00) begin n_err++; $display("FAIL arst_wr_en got %b want 00", rt_wr_en_o); end
      n_cmp++; if (empty_o !== 1'b1) begin n_err++; $display("FAIL arst_empty got %b want 1", empty_o); end
      n_cmp++; if (dp_num_avail_o !== 2'd2) begin n_err++; $display("FAIL arst_avail got %0d want 2", dp_num_avail_o); end
      tick();
      rst_i = 1'b0;
      idle();
      #1;
      n_cmp++; if (empty_o !== 1'b1) begin n_err++; $display("FAIL arst_dispatch_lost got %b want 1", empty_o); end
      n_cmp++; if (dp_rob_idx_o[4:0] !== 5'd0) begin n_err++; $display("FAIL arst_tail got %0d want 0", dp_rob_idx_o[4:0]); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full();
      do_reset();
      test_ooo();
      do_reset();
      test_mispredict();
      do_reset();
      test_wrap();
      do_reset();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
